// File: rtl/dual_step_pkg.sv
// Shared types and helpers for the dual-step accumulator: FSM state encoding
// and the untruncated step-sum helper used to form the W-bit invariant constant.
package dual_step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Callers truncate the result to their own W with a size cast.
  function automatic int unsigned step_sum(input int unsigned step_a,
                                           input int unsigned step_b);
    return step_a + step_b;
  endfunction

endpackage

// File: rtl/dual_step_inv_check.sv
// Sticky invariant checker for dual_step_accum, compiled only when
// DUAL_STEP_INV_CHECK_EN is defined.
`ifdef DUAL_STEP_INV_CHECK_EN
module dual_step_inv_check #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         check,
  input  logic [W-1:0] sum,
  input  logic [W-1:0] expected,
  output logic         inv_err
);

  logic r_err;

  // Once set the flag survives later starts; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (check && (sum != expected)) begin
      r_err <= 1'b1;
    end
  end

  assign inv_err = r_err;

endmodule
`endif

// File: rtl/dual_step_accum.sv
// Dual-step accumulator: index runs 0..n, each step adds STEP_A/STEP_B to a/b
// with per-cycle pairing; optional invariant checker under DUAL_STEP_INV_CHECK_EN.
module dual_step_accum
  import dual_step_pkg::*;
#(
  parameter int unsigned W         = 11,
  parameter int unsigned STEP_A    = 1,
  parameter int unsigned STEP_B    = 2,
  parameter int unsigned DEFAULT_N = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] n_in,
  input  logic         selector,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] n,
  output logic [W-1:0] i,
  output logic         busy,
  output logic         done,
  output logic         inv_err
);

  localparam logic [W-1:0] STEP_A_W    = W'(STEP_A);
  localparam logic [W-1:0] STEP_B_W    = W'(STEP_B);
  localparam logic [W-1:0] DEFAULT_N_W = W'(DEFAULT_N);
  localparam logic [W-1:0] ONE_W       = W'(1);
  localparam state_e       RESET_STATE = (DEFAULT_N_W == '0) ? ST_DONE : ST_RUN;

  state_e       r_state;
  state_e       w_state_next;
  logic [W-1:0] r_a, r_b, r_i, r_n;
  logic [W-1:0] w_a_next, w_b_next, w_i_next, w_n_next;

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_i_next     = r_i;
    w_n_next     = r_n;
    case (r_state)
      ST_RUN: begin
        if (r_i < r_n) begin
          w_i_next = r_i + ONE_W;
          w_a_next = r_a + (selector ? STEP_A_W : STEP_B_W);
          w_b_next = r_b + (selector ? STEP_B_W : STEP_A_W);
          if (w_i_next == r_n) begin
            w_state_next = ST_DONE;
          end
        end else begin
          // Unreachable in normal operation; bail out without touching data.
          w_state_next = ST_DONE;
        end
      end
      default: begin
        if (start) begin
          w_n_next     = n_in;
          w_a_next     = '0;
          w_b_next     = '0;
          w_i_next     = '0;
          w_state_next = (n_in == '0) ? ST_DONE : ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RESET_STATE;
      r_a     <= '0;
      r_b     <= '0;
      r_i     <= '0;
      r_n     <= DEFAULT_N_W;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_i     <= w_i_next;
      r_n     <= w_n_next;
    end
  end

  assign a    = r_a;
  assign b    = r_b;
  assign n    = r_n;
  assign i    = r_i;
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

`ifdef DUAL_STEP_INV_CHECK_EN
  localparam logic [W-1:0] STEP_SUM_W = W'(step_sum(STEP_A, STEP_B));

  logic         w_enter_done;
  logic [W-1:0] w_sum_next, w_expect_next, w_sum_cur, w_expect_cur;

  assign w_enter_done  = (r_state != ST_DONE) && (w_state_next == ST_DONE);
  assign w_sum_next    = w_a_next + w_b_next;
  assign w_expect_next = STEP_SUM_W * w_n_next;
  assign w_sum_cur     = r_a + r_b;
  assign w_expect_cur  = STEP_SUM_W * r_n;

  dual_step_inv_check #(.W(W)) u_inv_check (
    .clk      (clk),
    .rst      (rst),
    .check    (w_enter_done),
    .sum      (w_sum_next),
    .expected (w_expect_next),
    .inv_err  (inv_err)
  );

  a_done_invariant : assert property (
    @(posedge clk) disable iff (!rst)
    (r_state != ST_DONE) || (w_sum_cur == w_expect_cur)
  );
`else
  assign inv_err = 1'b0;
`endif

endmodule
